regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// Parametrised multi-read-port general register file with HI/LO pair, write-to-read forwarding
// and a per-register pending-write scoreboard. Sits in decode: the control unit reserves a destination
// at issue; writeback clears the reservation when it writes. A post-reset sweep FSM zeroes the array
// before 'ready' rises.
// PARAMETERS
// DATA_W    32  register width in bits
// ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
// NUM_RD    2   number of independent read ports (1..4)
// ZERO_REG  1   1: entry 0 reads 0, and writes/reservations to it are dropped; 0: entry 0 is ordinary
// PORTS
// clk       in   1               clock, all state on rising edge
// rst       in   1               asynchronous, active-low reset
// rd_addr   in   NUM_RD*ADDR_W   read addresses, port p at [p*ADDR_W +: ADDR_W]
// rd_data   out  NUM_RD*DATA_W   registered read data, port p at [p*DATA_W +: DATA_W]
// rd_busy   out  NUM_RD          registered scoreboard bit for each read address
// wr_en     in   1               writeback enable
// wr_addr   in   ADDR_W          writeback address
// wr_data   in   DATA_W          writeback data
// rsv_en    in   1               reserve (mark pending) rsv_addr
// rsv_addr  in   ADDR_W          register being reserved at issue
// hilo_we   in   1               write hi_wdata/lo_wdata together
// hi_wdata  in   DATA_W          HI write data
// lo_wdata  in   DATA_W          LO write data
// hi_rdata  out  DATA_W          HI contents, direct register output
// lo_rdata  out  DATA_W          LO contents, direct register output
// ready     out  1               1 once the init sweep has completed
// BEHAVIOUR
// - Reset (rst=0, asynchronous): rd_data=0, rd_busy=0, hi/lo=0, all scoreboard bits=0, sweep counter=0,
//   ready=0, FSM=INIT. The array itself is not reset. Reset asserted mid-sweep or mid-run restarts INIT.
// - FSM INIT: one entry per cycle, array[cnt]<=0, cnt++. After entry DEPTH-1 is written -> RUN with
//   ready=1 on the next cycle (DEPTH cycles after reset release). In INIT, wr_en/rsv_en/hilo_we are
//   ignored, and rd_data/rd_busy are held at 0.
// - FSM RUN: terminal state; exited only by reset.
// - Write (RUN): when wr_en, and wr_addr!=0 or ZERO_REG=0, array[wr_addr]<=wr_data and busy[wr_addr]<=0.
// - Read (RUN): 1-cycle latency. rd_data[p] <= value of rd_addr[p] at the clock edge:
//   * if ZERO_REG and addr==0 -> 0;
//   * else if wr_en and wr_addr==addr (write accepted) -> wr_data (write-first forwarding);
//   * else -> array[addr].
// - rd_busy[p] uses the same edge and the post-update scoreboard value, so it includes that cycle's
//   reserve and clear.
// - Reserve: when rsv_en and the address is writable, busy[rsv_addr]<=1.
//   rsv and wr to the same address in one cycle -> busy=1 (reserve wins: a new producer has issued);
//   the data is still written.
// - Double reserve of a busy register keeps it at 1 (no counting). A write to a non-busy register is
//   legal and leaves it at 0.
// - HI/LO: when hilo_we in RUN, both are updated on the edge; hi_rdata/lo_rdata show the new values the
//   next cycle. No forwarding.
// - Read ports are fully independent; any number may read the same address.
// - Width rules: no arithmetic except the sweep counter, which is ADDR_W+1 bits so it covers DEPTH
//   without wrap ambiguity.
// - Simulation-only $display trace of accepted writes, guarded by `ifndef SYNTHESIS.
// STRUCTURE
// - Package mips_rf_pkg: rf_state_t {RF_INIT, RF_RUN}, default DATA_W/ADDR_W localparams.
// - Sub-module rf_scoreboard: DEPTH-bit busy vector with set (rsv), clear (wr), set-priority, NUM_RD
//   lookup ports, and the same reset.
// - Top: array, sweep FSM, forwarding muxes, HI/LO registers. NUM_RD ports come from a generate loop.
// TESTING
// 1 Reset release: ready=0 for exactly 32 cycles, then 1. A read of any reg in the first RUN cycle
//   returns 0, and rd_busy=0.
// 2 wr_en, addr 9, data 0x20, with rd_addr0=9 in the same cycle -> rd_data0=0x20 on the next cycle
//   (forward). The following cycle also returns 0x20 from the array.
// 3 Write addr 0, data 0xDEAD with ZERO_REG=1 -> reading reg 0 returns 0. With ZERO_REG=0 it returns
//   0xDEAD.
// 4 rsv 10, then wr 10 of 0x30 two cycles later -> rd_busy for reg 10 is 1,1,0. rsv and wr of 10 in
//   the same cycle -> busy stays 1 and data is 0x30.
// 5 NUM_RD=3, all ports read regs 9,10,9 -> data 0x20,0x30,0x20. hilo_we with 0x1/0x2 -> hi/lo show
//   1/2 the next cycle.
// 6 Drop rst for 1 cycle mid-sweep (cycle 10) and mid-run -> ready=0, busy cleared, full 32-cycle
//   sweep repeats, and writes during INIT are dropped.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package mips_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Sweep FSM: INIT zeroes the array one entry per cycle, RUN is terminal.
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// A reservation sets the bit and a writeback clears it. When both hit the same
// register in one cycle, the set wins because a newer producer has just issued.
// Lookups are registered and see the post-update value of that same edge.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     look_en,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [NUM_RD-1:0] look_busy_q, look_busy_d;

  // Next busy vector: clear first, then set, so the set has priority.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  // Each lookup port reads the post-update vector; held low while disabled.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_look
    assign look_busy_d[gi] = look_en & busy_d[look_addr[gi*ADDR_W +: ADDR_W]];
  end

  // Busy vector and registered lookup results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      look_busy_q <= '0;
    end else begin
      busy_q      <= busy_d;
      look_busy_q <= look_busy_d;
    end
  end

  assign look_busy = look_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with HI/LO pair, write-first forwarding,
// pending-write scoreboard and a post-reset sweep that zeroes the array.
module regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     hilo_we,
  input  logic [DATA_W-1:0]        hi_wdata,
  input  logic [DATA_W-1:0]        lo_wdata,
  output logic [DATA_W-1:0]        hi_rdata,
  output logic [DATA_W-1:0]        lo_rdata,
  output logic                     ready
);

  localparam int              DEPTH    = 1 << ADDR_W;
  // The counter is one bit wider than an address so DEPTH itself is representable.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic run;
  logic wr_ok, rsv_ok;
  logic wr_accept, rsv_accept;

  assign run    = (state_q == RF_RUN);
  // Entry 0 is hardwired to zero when ZERO_REG is set, so it can never be written or reserved.
  assign wr_ok  = (ZERO_REG == 0) || (wr_addr != '0);
  assign rsv_ok = (ZERO_REG == 0) || (rsv_addr != '0);
  // Nothing from the pipeline is accepted until the sweep has finished.
  assign wr_accept  = run & wr_en & wr_ok;
  assign rsv_accept = run & rsv_en & rsv_ok;

  // Sweep FSM next state: step the counter through every entry, then park in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_IDX) state_d = RF_RUN;
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single array write port shared by the sweep (INIT) and writeback (RUN).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[ADDR_W-1:0];
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // Array storage; deliberately not reset, the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // HI/LO next values: updated together, only once running.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (run && hilo_we) begin
      hi_d = hi_wdata;
      lo_d = lo_wdata;
    end
  end

  // HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;
  assign ready    = run;

  // Independent read ports, each with its own zero check and forwarding mux.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_d, data_q;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

    // Read mux: zero during sweep, zero register, then same-cycle write, then array.
    always_comb begin
      data_d = mem[addr];
      if (!run) begin
        data_d = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        data_d = '0;
      end else if (wr_accept && (wr_addr == addr)) begin
        data_d = wr_data;
      end
    end

    // Registered read data for this port.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) data_q <= '0;
      else      data_q <= data_d;
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data_q;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (rsv_accept),
    .set_addr  (rsv_addr),
    .clr_en    (wr_accept),
    .clr_addr  (wr_addr),
    .look_en   (run),
    .look_addr (rd_addr),
    .look_busy (rd_busy)
  );

`ifndef SYNTHESIS
  // Trace of every write that actually lands in the array.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) $display("%m: write r%0d <= 0x%h", wr_addr, wr_data);
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 3-port ZERO_REG=1 instance plus a 1-port
// ZERO_REG=0 instance sharing the write/reserve/HI-LO inputs.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             hilo_we;
  logic [DW-1:0]    hi_wdata, lo_wdata, hi_rdata, lo_rdata;
  logic             ready;

  logic [AW-1:0]    rd_addr_z;
  logic [DW-1:0]    rd_data_z;
  logic [0:0]       rd_busy_z;
  logic [DW-1:0]    hi_z, lo_z;
  logic             ready_z;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_rdata(hi_rdata),
    .lo_rdata(lo_rdata), .ready(ready)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_z), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_rdata(hi_z),
    .lo_rdata(lo_z), .ready(ready_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    hilo_we  = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rd_addr   = {5'd17, 5'd31, 5'd5};
    rd_addr_z = 5'd3;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL reset_rd_busy: got %b want 000", rd_busy); end
    checks++; if ({hi_rdata, lo_rdata} !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_rdata, lo_rdata); end
    rst = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL reset_sweep_len: got %0d cycles want 32", n); end
    checks++; if (ready_z !== 1'b1) begin errors++; $display("FAIL reset_ready_z0: got %b want 1", ready_z); end
    tick();
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL first_run_read: got %h want 0", rd_data); end
    checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL first_run_busy: got %b want 000", rd_busy); end
    checks++; if (rd_data_z !== 32'h0) begin errors++; $display("FAIL first_run_read_z0: got %h want 0", rd_data_z); end
    $display("reset: sweep took %0d cycles", n);
  endtask

  task automatic test_forward();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h20;
    rd_addr = {5'd0, 5'd0, 5'd9};
    tick();
    checks++; if (rd_data[31:0] !== 32'h20) begin errors++; $display("FAIL fwd_same_cycle: got %h want 00000020", rd_data[31:0]); end
    idle();
    tick();
    checks++; if (rd_data[31:0] !== 32'h20) begin errors++; $display("FAIL fwd_from_array: got %h want 00000020", rd_data[31:0]); end
    $display("forward: r9 read %h", rd_data[31:0]);
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD;
    rd_addr = {5'd0, 5'd0, 5'd0};
    rd_addr_z = 5'd0;
    tick();
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL zero_fwd: got %h want 0", rd_data[31:0]); end
    checks++; if (rd_data_z !== 32'hDEAD) begin errors++; $display("FAIL zero_fwd_z0: got %h want 0000dead", rd_data_z); end
    idle();
    tick();
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL zero_array: got %h want 0", rd_data[31:0]); end
    checks++; if (rd_data_z !== 32'hDEAD) begin errors++; $display("FAIL zero_array_z0: got %h want 0000dead", rd_data_z); end
    $display("zero_reg: r0 reads %h (ZERO_REG=1) and %h (ZERO_REG=0)", rd_data[31:0], rd_data_z);
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd0, 5'd10, 5'd9};
    rsv_en = 1'b1; rsv_addr = 5'd10;
    tick();
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_rsv: got %b want 1", rd_busy[1]); end
    rsv_en = 1'b0;
    tick();
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_hold: got %b want 1", rd_busy[1]); end
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h33;
    tick();
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", rd_busy[1]); end
    checks++; if (rd_data[63:32] !== 32'h33) begin errors++; $display("FAIL sb_clear_data: got %h want 00000033", rd_data[63:32]); end
    rsv_en = 1'b1; rsv_addr = 5'd10; wr_data = 32'h30;
    tick();
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_rsv_wins: got %b want 1", rd_busy[1]); end
    checks++; if (rd_data[63:32] !== 32'h30) begin errors++; $display("FAIL sb_rsv_wr_data: got %h want 00000030", rd_data[63:32]); end
    idle();
    tick();
    checks++; if ({rd_busy[1], rd_data[63:32]} !== {1'b1, 32'h30}) begin errors++; $display("FAIL sb_after_both: got %b/%h want 1/00000030", rd_busy[1], rd_data[63:32]); end
    rsv_en = 1'b1; rsv_addr = 5'd10;
    tick();
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_double_rsv: got %b want 1", rd_busy[1]); end
    rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h30;
    tick();
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_single_clear: got %b want 0", rd_busy[1]); end
    wr_addr = 5'd9; wr_data = 32'h20; rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr_z = 5'd0;
    tick();
    checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL sb_nonbusy_wr_r0_rsv: got %b want 000", rd_busy); end
    checks++; if (rd_busy_z !== 1'b1) begin errors++; $display("FAIL sb_r0_rsv_z0: got %b want 1", rd_busy_z); end
    idle();
    $display("scoreboard: busy %b, z0 busy %b", rd_busy, rd_busy_z);
  endtask

  task automatic test_multiport();
    rd_addr = {5'd9, 5'd10, 5'd9};
    hilo_we = 1'b1; hi_wdata = 32'h1; lo_wdata = 32'h2;
    checks++; if ({hi_rdata, lo_rdata} !== 64'h0) begin errors++; $display("FAIL hilo_before: got %h/%h want 0/0", hi_rdata, lo_rdata); end
    tick();
    checks++; if (rd_data !== {32'h20, 32'h30, 32'h20}) begin errors++; $display("FAIL mp_read: got %h want 000000200000003000000020", rd_data); end
    checks++; if ({hi_rdata, lo_rdata} !== {32'h1, 32'h2}) begin errors++; $display("FAIL hilo_write: got %h/%h want 1/2", hi_rdata, lo_rdata); end
    hilo_we = 1'b0; hi_wdata = 32'hFF; lo_wdata = 32'hEE;
    tick();
    checks++; if ({hi_rdata, lo_rdata} !== {32'h1, 32'h2}) begin errors++; $display("FAIL hilo_hold: got %h/%h want 1/2", hi_rdata, lo_rdata); end
    idle();
    $display("multiport: data %h hi %h lo %h", rd_data, hi_rdata, lo_rdata);
  endtask

  task automatic test_reset_midrun_midsweep();
    int n;
    rd_addr = {5'd0, 5'd0, 5'd12};
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick();
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL mr_setup_busy: got %b want 1", rd_busy[0]); end
    idle();
    rst = 1'b0;
    #1;
    checks++; if ({ready, rd_busy, hi_rdata} !== {1'b0, 3'b000, 32'h0}) begin errors++; $display("FAIL mr_async_clear: got %b/%b/%h want 0/000/0", ready, rd_busy, hi_rdata); end
    tick();
    rst = 1'b1;
    // Pipeline activity during the sweep must be ignored.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd11;
    hilo_we = 1'b1; hi_wdata = 32'h7; lo_wdata = 32'h8;
    rd_addr = {5'd9, 5'd11, 5'd9};
    repeat (10) tick();
    checks++; if ({ready, rd_busy, rd_data[31:0]} !== {1'b0, 3'b000, 32'h0}) begin errors++; $display("FAIL ms_init_hold: got %b/%b/%h want 0/000/0", ready, rd_busy, rd_data[31:0]); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    idle();
    checks++; if (n !== 32) begin errors++; $display("FAIL ms_sweep_len: got %0d cycles want 32", n); end
    tick();
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL ms_wr_dropped: got %h want 0", rd_data); end
    checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL ms_rsv_dropped: got %b want 000", rd_busy); end
    checks++; if ({hi_rdata, lo_rdata} !== 64'h0) begin errors++; $display("FAIL ms_hilo_dropped: got %h/%h want 0/0", hi_rdata, lo_rdata); end
    $display("reset_mid: resweep took %0d cycles", n);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_zero_reg();
    test_scoreboard();
    test_multiport();
    test_reset_midrun_midsweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
